// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit lookahead group per stage.
// Optional macro CLA_SIGNED_OVF_EN adds the o_overflow output (signed overflow).
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_sub
`ifdef CLA_SIGNED_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int NUM_GROUPS = WIDTH / GROUP;

  if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  // Expanded lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             cin);
    logic [GROUP:0] c;
    logic           term;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_in;

  // Global stall: the whole pipe moves together, no bubble collapse.
  assign advance = !o_valid || i_ready;
  assign o_ready = advance;
  assign b_in    = i_sub ? ~i_add2 : i_add2;

  genvar k;
  for (k = 0; k < NUM_GROUPS; k++) begin : g_stage
    localparam int IN_W = WIDTH - GROUP * k;
    localparam int DONE = GROUP * (k + 1);

    logic [IN_W-1:0]  src_a;
    logic [IN_W-1:0]  src_b;
    logic             cin;
    logic             vld_d;
    logic             sub_d;
    logic [DONE-1:0]  sum_d;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] sum_grp;
    logic [GROUP:0]   c;

    logic             vld_q;
    logic             sub_q;
    logic             cry_q;
    logic [DONE-1:0]  sum_q;

    assign p       = src_a[GROUP-1:0] ^ src_b[GROUP-1:0];
    assign g       = src_a[GROUP-1:0] & src_b[GROUP-1:0];
    assign c       = cla_carries(p, g, cin);
    assign sum_grp = p ^ c[GROUP-1:0];

    if (k == 0) begin : g_head
      assign src_a = i_add1;
      assign src_b = b_in;
      assign cin   = i_sub;
      assign vld_d = i_valid;
      assign sub_d = i_sub;
      assign sum_d = sum_grp;
    end else begin : g_body
      assign src_a = g_stage[k-1].g_skew.a_q;
      assign src_b = g_stage[k-1].g_skew.b_q;
      assign cin   = g_stage[k-1].cry_q;
      assign vld_d = g_stage[k-1].vld_q;
      assign sub_d = g_stage[k-1].sub_q;
      assign sum_d = {sum_grp, g_stage[k-1].sum_q};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld_q <= 1'b0;
        sub_q <= 1'b0;
        cry_q <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        vld_q <= vld_d;
        sub_q <= sub_d;
        cry_q <= c[GROUP];
        sum_q <= sum_d;
      end
    end

    if (k < NUM_GROUPS - 1) begin : g_skew
      // Operand bits for the groups still ahead travel with the transaction.
      logic [IN_W-GROUP-1:0] a_q;
      logic [IN_W-GROUP-1:0] b_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= src_a[IN_W-1:GROUP];
          b_q <= src_b[IN_W-1:GROUP];
        end
      end
    end else begin : g_last
`ifdef CLA_SIGNED_OVF_EN
      logic ovf_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        ovf_q <= 1'b0;
        else if (advance) ovf_q <= c[GROUP] ^ c[GROUP-1];
      end
`endif
    end
  end

  assign o_valid  = g_stage[NUM_GROUPS-1].vld_q;
  assign o_sub    = g_stage[NUM_GROUPS-1].sub_q;
  assign o_result = {g_stage[NUM_GROUPS-1].cry_q, g_stage[NUM_GROUPS-1].sum_q};
`ifdef CLA_SIGNED_OVF_EN
  assign o_overflow = g_stage[NUM_GROUPS-1].g_last.ovf_q;
`endif

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshaking on both sides. Successor to the combinational carry-lookahead adder.
- Operand width is split into GROUP-bit lookahead groups; one group is resolved per pipeline stage, and the group carry is registered between stages.
- Sits on streaming arithmetic datapaths that need wide add/subtract at high clock rates with backpressure.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of GROUP (elaboration error otherwise)
GROUP, 4, bits per lookahead group (generate/propagate computed per bit, carries per group in parallel)
NUM_GROUPS, WIDTH/GROUP, derived localparam; pipeline depth and latency in cycles

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  upstream operand pair valid
o_ready  output  1  adder can accept operands this cycle
i_add1  input  WIDTH  operand A (unsigned)
i_add2  input  WIDTH  operand B (unsigned)
i_sub  input  1  0 = A+B, 1 = A-B, sampled with operands
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_result  output  WIDTH+1  sum/difference; MSB is carry-out
o_sub  output  1  i_sub of the transaction on o_result, carried through the pipeline

Behaviour:
- Reset (asynchronous, immediate on i_rst=1):
  - All stage valid bits, o_valid and o_sub clear to 0.
  - o_result and all stage data registers clear to 0.
  - o_ready is 1 during and after reset.
- Transfer rules:
  - Input accepted on a rising edge with i_valid && o_ready.
  - Output consumed on a rising edge with o_valid && i_ready.
- Stalling is global, no bubble collapse: advance = !o_valid || i_ready, and o_ready = advance.
  - When advance=0, every stage register holds.
  - When advance=1, every stage shifts by one.
  - An empty slot shifts in with valid=0 when i_valid=0.
- Stage k (k = 0..NUM_GROUPS-1) computes the following from the registered carry-in of stage k-1:
  - group k: per-bit p=a^b, g=a&b, internal carries by lookahead equations, sum bits and group carry-out.
  - stage 0 carry-in = i_sub.
- Subtract: B is replaced by ~B at stage 0, and carry-in is 1.
  - o_result[WIDTH] = 1 means no borrow (A >= B).
  - o_result[WIDTH-1:0] = (A-B) mod 2^WIDTH.
- Latency: exactly NUM_GROUPS cycles from acceptance to o_valid with no stalls. Throughput is 1 per cycle.
- Operand bits not yet consumed travel with the transaction (skew registers). Already-computed sum bits are delayed (deskew) so that o_result is aligned.
- Ordering: results emerge strictly in acceptance order; no drop, no duplication.
- Boundaries:
  - Full pipeline with i_ready=0 → o_ready=0 and data held indefinitely; upstream i_valid is ignored.
  - Simultaneous accept and consume in the same cycle is allowed and sustains full rate.
  - Max operands (all ones + all ones) → carry ripples across all group registers correctly; the result is 2^(WIDTH+1)-2.
- Reset mid-operation discards all in-flight transactions; no partial result appears after reset release.
- NUM_GROUPS=1 degenerates to a single registered CLA stage with latency 1.

Optional Feature:
Macro CLA_SIGNED_OVF_EN.
- Defined: adds output port o_overflow (1 bit), aligned with o_result and reset to 0. It is the signed two's-complement overflow of the operation, computed as carry-into-MSB XOR carry-out-of-MSB of the final group, with B inverted for subtract.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, GROUP=4. Reset, then i_add1=8'd200, i_add2=8'd100, i_sub=0, i_ready=1 → o_valid high exactly 2 cycles after acceptance, o_result=9'd300.
- Subtract: 8'd5 - 8'd9 → o_result=9'h0FC (MSB 0 = borrow). 8'd9 - 8'd5 → 9'h104.
- Back-to-back stream of 64 random pairs, i_ready=1, i_valid=1 every cycle → 64 results in order, no gaps after the first 2-cycle latency, all matching a reference model.
- Backpressure: hold i_ready=0 for 5 cycles with the pipe full → o_ready=0, o_result stable; release → queued results emerge in order, no loss.
- Carry ripple: 8'hFF + 8'hFF and 8'hFF + 8'h01 → 9'h1FE and 9'h100.
  - With CLA_SIGNED_OVF_EN: 8'h7F + 8'h01 → o_overflow=1; 8'h80 - 8'h01 → o_overflow=1.
- Assert i_rst for 1 cycle with 2 transactions in flight → o_valid=0 immediately; no stale result appears afterwards; the next accepted pair produces a correct result.
